addsub_serial: RTL and testbench

//  Parametrised, digit-serial successor of the 4-bit ripple adder/subtractor.

---
 rtl/addsub_serial.sv | 183 ++++++++++++++++++
 tb/tb_addsub_serial.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_serial.sv
// Digit-serial adder/subtractor: one DIGIT_W-bit slice plus a registered carry, N = WIDTH/DIGIT_W cycles per op.
// Optional flags (overflow, zero) are built when ADDSUB_SERIAL_FLAGS_EN is defined; otherwise both ports are tied low.
module addsub_serial #(
    parameter int WIDTH   = 8,
    parameter int DIGIT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             subtract_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   result,
    output logic             overflow,
    output logic             zero
);

    localparam int N     = WIDTH / DIGIT_W;
    localparam int CNT_W = $clog2(N) + 1;

    generate
        if (WIDTH % DIGIT_W != 0) begin : g_bad_digit_w
            $error("addsub_serial: WIDTH must be a multiple of DIGIT_W");
        end
        if (WIDTH < 2) begin : g_bad_width
            $error("addsub_serial: WIDTH must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic               carry_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               sub_reg;
    logic [WIDTH-1:0]   sum_reg;
    logic [WIDTH-1:0]   sum_next;
    logic [WIDTH:0]     result_reg;

    logic               accept;
    logic               run_last;
    logic [N-1:0]       digit_sel;
    logic [DIGIT_W-1:0] a_digit [N];
    logic [DIGIT_W-1:0] b_digit [N];
    logic [DIGIT_W-1:0] cur_a;
    logic [DIGIT_W-1:0] cur_b;
    logic [DIGIT_W:0]   digit_full;

    // Per-digit taps of the operand registers and one-hot select from the counter.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_digit
            assign a_digit[gi]   = a_reg[gi*DIGIT_W +: DIGIT_W];
            assign b_digit[gi]   = b_reg[gi*DIGIT_W +: DIGIT_W];
            assign digit_sel[gi] = (cnt_reg == CNT_W'(gi));
        end
    endgenerate

    always_comb begin
        cur_a = '0;
        cur_b = '0;
        for (int i = 0; i < N; i++) begin
            if (digit_sel[i]) begin
                cur_a = a_digit[i];
                cur_b = b_digit[i];
            end
        end
    end

    assign digit_full = {1'b0, cur_a} + {1'b0, cur_b} + {{DIGIT_W{1'b0}}, carry_reg};
    assign run_last   = (state_reg == ST_RUN) && digit_sel[N-1];

    // Partial sum lives here; the result port only changes once the last digit lands.
    always_comb begin
        sum_next = sum_reg;
        if (state_reg == ST_RUN) begin
            for (int i = 0; i < N; i++) begin
                if (digit_sel[i]) begin
                    sum_next[i*DIGIT_W +: DIGIT_W] = digit_full[DIGIT_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (digit_sel[N-1]) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg    <= '0;
            carry_reg  <= 1'b0;
            a_reg      <= '0;
            b_reg      <= '0;
            sub_reg    <= 1'b0;
            sum_reg    <= '0;
            result_reg <= '0;
        end else if (accept) begin
            // Subtraction is A + ~B + 1: invert B once here and seed the carry with 1.
            cnt_reg   <= '0;
            carry_reg <= subtract_mode;
            a_reg     <= operand_a;
            b_reg     <= operand_b ^ {WIDTH{subtract_mode}};
            sub_reg   <= subtract_mode;
            sum_reg   <= '0;
        end else if (state_reg == ST_RUN) begin
            cnt_reg   <= cnt_reg + CNT_W'(1);
            carry_reg <= digit_full[DIGIT_W];
            sum_reg   <= sum_next;
            if (run_last) begin
                result_reg <= {digit_full[DIGIT_W] ^ sub_reg, sum_next};
            end
        end
    end

    assign result = result_reg;

`ifdef ADDSUB_SERIAL_FLAGS_EN
    logic overflow_reg;
    logic zero_reg;

    // B is already inverted for subtract, so one same-sign test covers both modes.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_reg <= 1'b0;
            zero_reg     <= 1'b0;
        end else if (run_last) begin
            overflow_reg <= (cur_a[DIGIT_W-1] == cur_b[DIGIT_W-1]) &&
                            (digit_full[DIGIT_W-1] != cur_a[DIGIT_W-1]);
            zero_reg     <= (sum_next == '0);
        end
    end

    assign overflow = overflow_reg;
    assign zero     = zero_reg;
`else
    assign overflow = 1'b0;
    assign zero     = 1'b0;
`endif

endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial (WIDTH=8, DIGIT_W=2): directed cases plus randomized ops against an arithmetic model.
module tb_addsub_serial;

    localparam int W  = 8;
    localparam int DW = 2;
    localparam int N  = W / DW;
`ifdef ADDSUB_SERIAL_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic         subtract_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   result;
    logic         overflow;
    logic         zero;

    addsub_serial #(.WIDTH(W), .DIGIT_W(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .subtract_mode (subtract_mode),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .overflow      (overflow),
        .zero          (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int n_ops    = 0;

    typedef struct packed {
        logic [W:0]   res;
        logic         ovf;
        logic         zro;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
    } exp_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Plain arithmetic reference: 9-bit unsigned sum/difference and signed range test.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        exp_t m;
        int   sa;
        int   sb;
        int   s;
        sa    = int'($signed(a));
        sb    = int'($signed(b));
        s     = sub ? (sa - sb) : (sa + sb);
        m.res = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
        m.ovf = FLAGS && ((s > 127) || (s < -128));
        m.zro = FLAGS && (m.res[W-1:0] == '0);
        m.a   = a;
        m.b   = b;
        m.sub = sub;
        return m;
    endfunction

    // Cycle-level expectation of the handshake, advanced once per clock.
    bit         mon_en   = 1'b0;
    bit         pending  = 1'b0;
    int         run_cnt  = 0;
    exp_t       cur;
    logic [W:0] port_res = '0;
    logic       port_ovf = 1'b0;
    logic       port_zro = 1'b0;
    logic [W:0] last_res;
    logic       last_ovf;
    logic       last_zro;

    always @(negedge clk) begin
        if (mon_en) begin
            if (pending && run_cnt >= N) begin
                port_res = cur.res;
                port_ovf = cur.ovf;
                port_zro = cur.zro;
            end
            chk("in_ready", in_ready, !pending);
            chk("out_valid", out_valid, pending && run_cnt >= N);
            chk("result", result, port_res);
            chk("overflow", overflow, port_ovf);
            chk("zero", zero, port_zro);
            if (out_valid && out_ready) begin
                last_res = result;
                last_ovf = overflow;
                last_zro = zero;
                n_ops++;
                $display("op %0d: a=%02h b=%02h sub=%0d -> result=%03h ovf=%0d zero=%0d (model %03h/%0d/%0d)",
                         n_ops, cur.a, cur.b, cur.sub, result, overflow, zero, cur.res, cur.ovf, cur.zro);
            end
        end
        if (rst) begin
            pending  = 1'b0;
            run_cnt  = 0;
            port_res = '0;
            port_ovf = 1'b0;
            port_zro = 1'b0;
        end else if (pending) begin
            if (run_cnt >= N) begin
                if (out_ready) pending = 1'b0;
            end else begin
                run_cnt++;
            end
        end else if (in_valid) begin
            pending = 1'b1;
            run_cnt = 0;
            cur     = model(operand_a, operand_b, subtract_mode);
        end
    end

    // Inputs change 1 time unit after the rising edge, away from the monitor's sample point.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input int stall);
        int t;
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("wait_in_ready", in_ready, 1);
        in_valid      = 1'b1;
        operand_a     = a;
        operand_b     = b;
        subtract_mode = sub;
        out_ready     = (stall == 0);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        operand_a = W'($urandom);
        operand_b = W'($urandom);
        t = 0;
        while (!out_valid && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("wait_out_valid", out_valid, 1);
        for (int i = 0; i < stall; i++) begin
            in_valid      = 1'($urandom_range(0, 1));
            operand_a     = W'($urandom);
            subtract_mode = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    initial begin
        exp_t m;
        rst           = 1'b1;
        in_valid      = 1'b0;
        out_ready     = 1'b0;
        operand_a     = '0;
        operand_b     = '0;
        subtract_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_result", result, 0);
        chk("reset_overflow", overflow, 0);
        chk("reset_zero", zero, 0);

        m = model(8'd200, 8'd100, 1'b0);
        chk("model_200p100", m.res, 9'h12C);
        m = model(8'h05, 8'h09, 1'b1);
        chk("model_5m9", m.res, 9'h1FC);
        m = model(8'h7F, 8'h01, 1'b0);
        chk("model_127p1_ovf", m.ovf, FLAGS);

        do_op(8'd200, 8'd100, 1'b0, 0);
        chk("add_200_100", last_res, 9'h12C);
        chk("add_200_100_ovf", last_ovf, 0);
        chk("add_200_100_zero", last_zro, 0);
        do_op(8'h05, 8'h09, 1'b1, 0);
        chk("sub_5_9", last_res, 9'h1FC);
        chk("sub_5_9_ovf", last_ovf, 0);
        do_op(8'h09, 8'h05, 1'b1, 1);
        chk("sub_9_5", last_res, 9'h004);
        do_op(8'h7F, 8'h01, 1'b0, 0);
        chk("add_127_1", last_res, 9'h080);
        chk("add_127_1_ovf", last_ovf, FLAGS);
        chk("add_127_1_zero", last_zro, 0);
        do_op(8'h80, 8'h80, 1'b1, 0);
        chk("sub_80_80", last_res, 9'h000);
        chk("sub_80_80_zero", last_zro, FLAGS);
        chk("sub_80_80_ovf", last_ovf, 0);
        do_op(8'h10, 8'h20, 1'b0, 3);
        chk("stall_add", last_res, 9'h030);

        // Abort mid-RUN: rst sampled on the second RUN cycle.
        in_valid      = 1'b1;
        operand_a     = 8'h55;
        operand_b     = 8'h22;
        subtract_mode = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_result", result, 0);
        do_op(8'h03, 8'h04, 1'b0, 0);
        chk("after_abort_3p4", last_res, 9'h007);

        for (int k = 0; k < 1000; k++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
